pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Fetch-stage sequencer that owns the architectural PC register and drives the instruction-memory request/response handshake. It takes next-PC redirects from EX (branch, jal, jalr) and load-use stalls from ID. It also accepts an ebreak halt request. It presents one fetched instruction at a time to ID through a valid/ready buffer, with at most one memory request outstanding.

Parameters:
XLEN, 64, width of PC and addresses
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  IMEM accepts request this cycle
imem_req_addr  output  XLEN  fetch address (= pc)
imem_resp_valid  input  1  IMEM returns instruction (one per accepted request, ≥1 cycle after acceptance)
imem_resp_inst  input  32  returned instruction word
redirect_valid  input  1  EX redirect (taken branch/jal/jalr) this cycle
redirect_pc  input  XLEN  redirect target
stall  input  1  ID load-use hazard; blocks consumption
halt_req  input  1  ebreak retired; stop fetching
id_ready  input  1  ID can accept instruction
if_valid  output  1  if_inst/if_pc valid to ID
if_pc  output  XLEN  PC of presented instruction
if_inst  output  32  presented instruction
halted  output  1  fetch permanently stopped

Behaviour:
- States: REQ, WAIT, HOLD, DRAIN, HALT. Priority within a cycle: rst > redirect_valid > halt_req > normal flow.
- Reset (rst=1 at edge): state=REQ, pc=RESET_PC, drop=0, if_valid=0, if_pc=0, if_inst=0, halted=0. imem_req_valid=0 during the reset cycle.
- REQ: imem_req_valid=1, imem_req_addr=pc (combinational from pc). On imem_req_ready=1, go to WAIT. IMEM contract: addr may change while valid is high and the request has not been accepted.
- WAIT: on imem_resp_valid:
  - drop=1: discard the response, clear drop, go to REQ.
  - drop=0: latch if_inst=imem_resp_inst and if_pc=pc, set if_valid=1, pc=pc+4 (modulo 2^XLEN), go to HOLD.
- HOLD: if_valid=1 and outputs stable. Consumption occurs when id_ready=1 and stall=0: clear if_valid and go to REQ. Back-to-back throughput is one instruction per 3 cycles minimum (REQ, WAIT, HOLD), with zero-wait IMEM.
- Redirect (any state except HALT): pc=redirect_pc with bits [1:0] forced to 0, and if_valid cleared.
  - REQ, not accepted: stay in REQ; the next cycle issues the new address.
  - REQ, accepted the same cycle: go to WAIT with drop=1.
  - WAIT with no response this cycle: stay in WAIT, drop=1.
  - WAIT with response this cycle: discard it and go to REQ.
  - HOLD: go to REQ.
  - DRAIN: redirect is ignored.
  - A redirect in the same cycle as a consumption wins; the instruction is treated as consumed and the redirect applies.
- halt_req (no redirect that cycle):
  - REQ not accepted, or HOLD: clear if_valid and go to HALT.
  - REQ accepted the same cycle, or WAIT with no response: go to DRAIN.
  - WAIT with response this cycle: discard it and go to HALT.
- DRAIN: imem_req_valid=0. On imem_resp_valid, discard the response and go to HALT.
- HALT: imem_req_valid=0, if_valid=0, halted=1, pc frozen. Only rst exits.
- stall has no effect outside HOLD. Never more than one outstanding IMEM request. imem_resp_valid outside WAIT/DRAIN is a protocol error and is ignored.

Test Plan:
- Reset then free-run with 0-wait IMEM, id_ready=1 → requests at 0x8000_0000, 0x8000_0004, 0x8000_0008; if_pc follows; if_valid pulses every 3rd cycle.
- Hold stall=1 for 4 cycles while in HOLD → if_valid stays 1, if_inst unchanged, no new request; release → next request at if_pc+4.
- Redirect to 0x8000_0100 while WAIT (response 2 cycles late) → late response dropped (if_valid stays 0), next request addr=0x8000_0100.
- Redirect and accepted request in same cycle, plus redirect_pc=0x8000_0103 → in-flight response dropped, next addr=0x8000_0100.
- halt_req while WAIT → no further requests, response discarded, halted=1 after response; rst → fetch resumes at 0x8000_0000.
- pc=64'hFFFF_FFFF_FFFF_FFFC fetched → next request addr=0 (wrap).

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response bundle shared by the fetch sequencer
// (master) and the instruction memory (slave).
interface pc_fetch_ctrl_if #(
    parameter int unsigned XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_inst;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_inst
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_inst
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one IMEM request at a time,
// and hands each fetched instruction to ID through a valid/ready buffer.
// Handles EX redirects, ID stalls and an ebreak halt.
module pc_fetch_ctrl #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    pc_fetch_ctrl_if.master   imem,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [XLEN-1:0]   if_pc,
    output logic [31:0]       if_inst,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [31:0]     if_inst_q, if_inst_d;

    logic            req_fire;
    logic [XLEN-1:0] redirect_aligned;

    // Request is only presented in REQ and never while reset is asserted.
    always_comb begin
        imem.imem_req_valid = (state_q == S_REQ) && !rst;
        imem.imem_req_addr  = pc_q;
        req_fire            = imem.imem_req_valid && imem.imem_req_ready;
        redirect_aligned    = redirect_pc & ~XLEN'(3);
        if_valid            = if_valid_q;
        if_pc               = if_pc_q;
        if_inst             = if_inst_q;
        halted              = (state_q == S_HALT);
    end

    // Next-state logic; redirect outranks halt, which outranks normal flow.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;

        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d       = redirect_aligned;
                    if_valid_d = 1'b0;
                    if (req_fire) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (halt_req) begin
                    if (req_fire) begin
                        state_d = S_DRAIN;
                    end else begin
                        if_valid_d = 1'b0;
                        state_d    = S_HALT;
                    end
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d       = redirect_aligned;
                    if_valid_d = 1'b0;
                    if (imem.imem_resp_valid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (halt_req) begin
                    if (imem.imem_resp_valid) begin
                        state_d = S_HALT;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (imem.imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        if_inst_d  = imem.imem_resp_inst;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + XLEN'(4);
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d       = redirect_aligned;
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end else if (halt_req) begin
                    if_valid_d = 1'b0;
                    state_d    = S_HALT;
                end else if (id_ready && !stall) begin
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem.imem_resp_valid) begin
                    drop_d  = 1'b0;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if_valid_d = 1'b0;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a small IMEM responder model.
module tb_pc_fetch_ctrl;

    localparam int unsigned XLEN = 64;

    logic            clk;
    logic            rst;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            stall;
    logic            halt_req;
    logic            id_ready;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_inst;
    logic            halted;

    int unsigned n_checks;
    int unsigned n_pass;

    int unsigned     mem_lat;
    logic [XLEN-1:0] acc_q[$];

    pc_fetch_ctrl_if #(.XLEN(XLEN)) bus ();

    pc_fetch_ctrl #(
        .XLEN     (XLEN),
        .RESET_PC (64'h0000_0000_8000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .halt_req       (halt_req),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [XLEN-1:0] a);
        return a[31:0] ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // IMEM responder: one response mem_lat cycles after the cycle following acceptance.
    initial begin
        logic            acc_now;
        logic            pend;
        int unsigned     cnt;
        logic [XLEN-1:0] paddr;
        logic [XLEN-1:0] addr_now;
        pend = 1'b0;
        cnt  = 0;
        paddr = '0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_inst  = '0;
        forever begin
            @(negedge clk);
            acc_now  = bus.imem_req_valid && bus.imem_req_ready;
            addr_now = bus.imem_req_addr;
            @(posedge clk);
            #1;
            bus.imem_resp_valid = 1'b0;
            if (acc_now) begin
                acc_q.push_back(addr_now);
                pend  = 1'b1;
                cnt   = mem_lat;
                paddr = addr_now;
            end
            if (pend) begin
                if (cnt == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_inst  = inst_of(paddr);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0]      pat;
        logic [XLEN-1:0] exp_pc;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        stall = 1'b0;
        halt_req = 1'b0;
        id_ready = 1'b1;
        bus.imem_req_ready = 1'b1;
        mem_lat = 0;

        tick();
        tick();
        @(negedge clk);
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_if_valid", 64'(if_valid), 64'd0);
        check("rst_if_pc", if_pc, 64'd0);
        check("rst_if_inst", 64'(if_inst), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        tick();
        rst = 1'b0;

        // Free run, zero-wait IMEM.
        exp_pc = 64'h8000_0000;
        pat = '0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            pat[i] = if_valid;
            if (if_valid) begin
                check("run_if_pc", if_pc, exp_pc);
                check("run_if_inst", 64'(if_inst), 64'(inst_of(exp_pc)));
                exp_pc = exp_pc + 64'd4;
            end
            tick();
        end
        check("run_valid_pattern", 64'(pat), 64'(9'b100_100_100));
        check("run_req_count", 64'(acc_q.size()), 64'd3);
        check("run_req0", acc_q[0], 64'h8000_0000);
        check("run_req1", acc_q[1], 64'h8000_0004);
        check("run_req2", acc_q[2], 64'h8000_0008);

        // Stall in HOLD.
        stall = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_if_valid", 64'(if_valid), 64'd1);
            check("stall_if_pc", if_pc, 64'h8000_000C);
            check("stall_if_inst", 64'(if_inst), 64'(inst_of(64'h8000_000C)));
            check("stall_no_req", 64'(bus.imem_req_valid), 64'd0);
            tick();
        end
        stall = 1'b0;
        mem_lat = 2;
        @(negedge clk);
        check("unstall_if_valid", 64'(if_valid), 64'd1);
        tick();
        @(negedge clk);
        check("unstall_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("unstall_req_addr", bus.imem_req_addr, 64'h8000_0010);
        tick();

        // Redirect while WAIT with a late response.
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0100;
        @(negedge clk);
        check("wait_redir_no_req", 64'(bus.imem_req_valid), 64'd0);
        tick();
        redirect_valid = 1'b0;
        mem_lat = 0;
        @(negedge clk);
        check("wait_redir_if_valid_a", 64'(if_valid), 64'd0);
        tick();
        @(negedge clk);
        check("wait_redir_if_valid_b", 64'(if_valid), 64'd0);
        tick();

        // Redirect with misaligned target in the same cycle as acceptance.
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0103;
        @(negedge clk);
        check("wait_redir_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("wait_redir_req_addr", bus.imem_req_addr, 64'h8000_0100);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("acc_redir_if_valid", 64'(if_valid), 64'd0);
        check("acc_redir_no_req", 64'(bus.imem_req_valid), 64'd0);
        tick();
        @(negedge clk);
        check("acc_redir_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("acc_redir_req_addr", bus.imem_req_addr, 64'h8000_0100);
        check("acc_redir_if_valid2", 64'(if_valid), 64'd0);
        tick();
        tick();
        @(negedge clk);
        check("acc_redir_present", 64'(if_valid), 64'd1);
        check("acc_redir_if_pc", if_pc, 64'h8000_0100);
        check("acc_redir_if_inst", 64'(if_inst), 64'(inst_of(64'h8000_0100)));
        mem_lat = 1;
        tick();
        @(negedge clk);
        check("halt_pre_addr", bus.imem_req_addr, 64'h8000_0104);
        tick();

        // Halt while WAIT.
        halt_req = 1'b1;
        @(negedge clk);
        check("halt_wait_no_req", 64'(bus.imem_req_valid), 64'd0);
        tick();
        halt_req = 1'b0;
        @(negedge clk);
        check("drain_halted", 64'(halted), 64'd0);
        check("drain_no_req", 64'(bus.imem_req_valid), 64'd0);
        tick();
        @(negedge clk);
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_if_valid", 64'(if_valid), 64'd0);
        check("halt_pc_frozen", bus.imem_req_addr, 64'h8000_0104);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("halt_no_req", 64'(bus.imem_req_valid), 64'd0);
            check("halt_sticky", 64'(halted), 64'd1);
            tick();
        end
        check("halt_req_count", 64'(acc_q.size()), 64'd8);

        // Reset out of HALT, then wrap at the top of the address space.
        rst = 1'b1;
        mem_lat = 0;
        tick();
        rst = 1'b0;
        bus.imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        check("rerst_halted", 64'(halted), 64'd0);
        check("rerst_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("rerst_req_addr", bus.imem_req_addr, 64'h8000_0000);
        tick();
        redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        check("wrap_req_addr", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        tick();
        @(negedge clk);
        check("wrap_if_valid", 64'(if_valid), 64'd1);
        check("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_if_inst", 64'(if_inst), 64'h0000_0000_FFFF_FFEF);
        tick();
        @(negedge clk);
        check("wrap_next_valid", 64'(bus.imem_req_valid), 64'd1);
        check("wrap_next_addr", bus.imem_req_addr, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
